// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle LEGv8 core: sequences fetch/decode/execute/memory/write-back
// over one shared datapath. Optional retired-instruction counter via MULTICYCLE_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int OPCODE_W = 11,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                pc_src,
  output logic                ir_we,
  output logic                reg_we,
  output logic                reg2loc,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_to_reg,
  output logic                illegal,
  output logic [3:0]          state
`ifdef MULTICYCLE_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]    retired
`endif
);

  if (OPCODE_W != 11 || CNT_W < 1) begin : g_param_check
    $error("multicycle_ctrl: OPCODE_W must be 11 and CNT_W must be at least 1");
  end

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    ADDR   = 4'd3,
    MEM_RD = 4'd4,
    MEM_WR = 4'd5,
    WB_R   = 4'd6,
    WB_LD  = 4'd7,
    BRANCH = 4'd8
  } state_e;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_we;
    logic       mem_to_reg;
    logic       pc_src;
    logic       in_fetch;
    logic       in_branch;
  } moore_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(11'b10001011000);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(11'b11001011000);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(11'b10001010000);
  localparam logic [OPCODE_W-1:0] OP_ORR  = OPCODE_W'(11'b10101010000);
  localparam logic [OPCODE_W-1:0] OP_LDUR = OPCODE_W'(11'b11111000010);
  localparam logic [OPCODE_W-1:0] OP_STUR = OPCODE_W'(11'b11111000000);

  // Opcode-independent outputs of a state; registered alongside the state itself.
  function automatic moore_t moore_of(input state_e s);
    moore_t m;
    m = '0;
    case (s)
      FETCH:  begin m.mem_rd = 1'b1; m.in_fetch = 1'b1; end
      EXEC_R: m.alu_op = 2'b10;
      WB_R:   begin m.reg_we = 1'b1; m.alu_op = 2'b10; end
      ADDR:   m.alu_src = 1'b1;
      MEM_RD: begin m.mem_rd = 1'b1; m.alu_src = 1'b1; end
      MEM_WR: begin m.mem_wr = 1'b1; m.alu_src = 1'b1; end
      WB_LD:  begin m.reg_we = 1'b1; m.mem_to_reg = 1'b1; end
      BRANCH: begin m.alu_op = 2'b01; m.pc_src = 1'b1; m.in_branch = 1'b1; end
      default: ;
    endcase
    return m;
  endfunction

  state_e state_q, state_d;
  moore_t mo_q;

  logic is_rtype, is_ldur, is_stur, is_cbz, is_legal;

  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_ORR);
  assign is_ldur  = (opcode == OP_LDUR);
  assign is_stur  = (opcode == OP_STUR);
  assign is_cbz   = (opcode[OPCODE_W-1 -: 8] == 8'b10110100);
  assign is_legal = is_rtype || is_ldur || is_stur || is_cbz;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (is_rtype)                state_d = EXEC_R;
        else if (is_ldur || is_stur) state_d = ADDR;
        else if (is_cbz)             state_d = BRANCH;
        else                         state_d = FETCH;
      end
      EXEC_R: state_d = WB_R;
      WB_R:   state_d = FETCH;
      ADDR:   state_d = is_stur ? MEM_WR : MEM_RD;
      MEM_RD: if (mem_ready) state_d = WB_LD;
      MEM_WR: if (mem_ready) state_d = FETCH;
      WB_LD:  state_d = FETCH;
      BRANCH: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      mo_q    <= moore_of(FETCH);
    end else begin
      state_q <= state_d;
      mo_q    <= moore_of(state_d);
    end
  end

  // Reset forces every control output low so an abandoned access never reaches memory or the regfile.
  assign pc_we      = !reset && ((mo_q.in_fetch && mem_ready) || (mo_q.in_branch && zero));
  assign ir_we      = !reset && mo_q.in_fetch && mem_ready;
  assign pc_src     = !reset && mo_q.pc_src;
  assign reg_we     = !reset && mo_q.reg_we;
  assign alu_src    = !reset && mo_q.alu_src;
  assign alu_op     = reset ? 2'b00 : mo_q.alu_op;
  assign mem_rd     = !reset && mo_q.mem_rd;
  assign mem_wr     = !reset && mo_q.mem_wr;
  assign mem_to_reg = !reset && mo_q.mem_to_reg;
  assign illegal    = !reset && (state_q == DECODE) && !is_legal;
  assign reg2loc    = !reset && (((state_q == DECODE) && (is_stur || is_cbz)) ||
                                 ((state_q == ADDR) && is_stur) ||
                                 (state_q == MEM_WR) || (state_q == BRANCH));
  assign state      = state_q;

`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  assign retire = (state_q == WB_R) || (state_q == WB_LD) || (state_q == BRANCH) ||
                  ((state_q == MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_W'(1);
  end

  assign retired = reset ? '0 : retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks R-type, LDUR with waits, CBZ, illegal, STUR and reset abort.
module tb_multicycle_ctrl;

  logic        clk, reset, zero, mem_ready;
  logic [10:0] opcode;
  logic        pc_we, pc_src, ir_we, reg_we, reg2loc, alu_src, mem_rd, mem_wr, mem_to_reg, illegal;
  logic [1:0]  alu_op;
  logic [3:0]  state;
`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_BAD  = 11'b00000000000;

  multicycle_ctrl #(.OPCODE_W(11), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we), .reg2loc(reg2loc),
    .alu_src(alu_src), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
`ifdef MULTICYCLE_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc_we,pc_src,ir_we,reg_we, reg2loc,alu_src,alu_op, mem_rd,mem_wr,mem_to_reg,illegal}
  logic [15:0] obs;
  assign obs = {state, pc_we, pc_src, ir_we, reg_we, reg2loc, alu_src, alu_op,
                mem_rd, mem_wr, mem_to_reg, illegal};

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0;
    for (int i = 0; i < 5; i++) begin
      tick; chk("reset", obs, 16'h0000);
    end
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_reset", retired, 0);
`endif
    reset = 1'b0; #1; chk("fetch_first", obs, 16'h0A08);

    // ADD: 0,1,2,6,0
    tick; opcode = OP_ADD; #1; chk("add_decode", obs, 16'h1000);
    tick; #1; chk("add_exec", obs, 16'h2020);
    tick; #1; chk("add_wb", obs, 16'h6120);
    tick; #1; chk("add_fetch", obs, 16'h0A08);
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_add", retired, 1);
`endif

    // LDUR with 3 wait cycles in MEM_RD
    tick; opcode = OP_LDUR; #1; chk("ldur_decode", obs, 16'h1000);
    tick; #1; chk("ldur_addr", obs, 16'h3040);
    tick; mem_ready = 1'b0; #1; chk("ldur_mem_w1", obs, 16'h4048);
    tick; #1; chk("ldur_mem_w2", obs, 16'h4048);
    tick; #1; chk("ldur_mem_w3", obs, 16'h4048);
    tick; mem_ready = 1'b1; #1; chk("ldur_mem_done", obs, 16'h4048);
    tick; #1; chk("ldur_wb", obs, 16'h7102);
    tick; #1; chk("ldur_fetch", obs, 16'h0A08);
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_ldur", retired, 2);
`endif

    // FETCH wait state
    mem_ready = 1'b0; #1; chk("fetch_wait1", obs, 16'h0008);
    tick; #1; chk("fetch_wait2", obs, 16'h0008);
    mem_ready = 1'b1; #1; chk("fetch_go", obs, 16'h0A08);

    // CBZ taken
    tick; opcode = OP_CBZ; #1; chk("cbz1_decode", obs, 16'h1080);
    tick; zero = 1'b1; #1; chk("cbz1_branch", obs, 16'h8C90);
    tick; zero = 1'b0; #1; chk("cbz1_fetch", obs, 16'h0A08);
    // CBZ not taken
    tick; opcode = OP_CBZ; #1; chk("cbz0_decode", obs, 16'h1080);
    tick; zero = 1'b0; #1; chk("cbz0_branch", obs, 16'h8490);
    tick; #1; chk("cbz0_fetch", obs, 16'h0A08);
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_cbz", retired, 4);
`endif

    // Illegal opcode
    tick; opcode = OP_BAD; #1; chk("illegal_decode", obs, 16'h1001);
    tick; #1; chk("illegal_fetch", obs, 16'h0A08);
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_illegal", retired, 4);
`endif

    // STUR with one wait cycle, completes
    tick; opcode = OP_STUR; #1; chk("stur_decode", obs, 16'h1080);
    tick; #1; chk("stur_addr", obs, 16'h30C0);
    tick; mem_ready = 1'b0; #1; chk("stur_mem_wait", obs, 16'h50C4);
    mem_ready = 1'b1; #1; chk("stur_mem_done", obs, 16'h50C4);
    tick; #1; chk("stur_fetch", obs, 16'h0A08);
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_stur", retired, 5);
`endif

    // STUR abandoned by reset during the memory wait
    tick; opcode = OP_STUR; #1; chk("sturr_decode", obs, 16'h1080);
    tick; #1; chk("sturr_addr", obs, 16'h30C0);
    tick; mem_ready = 1'b0; #1; chk("sturr_mem_wait", obs, 16'h50C4);
    reset = 1'b1;
    tick; #1; chk("sturr_reset", obs, 16'h0000);
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_after_reset", retired, 0);
`endif
    reset = 1'b0; mem_ready = 1'b1; #1; chk("sturr_fetch", obs, 16'h0A08);

    // Three back-to-back ADDs
    for (int k = 0; k < 3; k++) begin
      tick; opcode = OP_ADD; #1; chk("add3_decode", obs, 16'h1000);
      tick; #1; chk("add3_exec", obs, 16'h2020);
      tick; #1; chk("add3_wb", obs, 16'h6120);
      tick; #1; chk("add3_fetch", obs, 16'h0A08);
    end
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk32("retired_three_adds", retired, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle variant of the LEGv8 core.
- Sequences one shared datapath (PC, IR, register file, ALU, unified memory) over 3-5 cycles per instruction by driving the enables and selects of the datapath's flopr-based state registers.
- Sits between IR[31:21] and the datapath. Handles memory wait states through a ready handshake.

Parameters:
- OPCODE_W, 11, width of the opcode field taken from IR[31:21]
- CNT_W, 32, width of the retired-instruction counter (optional feature only)

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- opcode  input  OPCODE_W  IR[31:21] of the currently latched instruction
- zero  input  1  ALU zero flag, valid in BRANCH
- mem_ready  input  1  unified memory completes the current access this cycle
- pc_we  output  1  PC register load enable
- pc_src  output  1  0 = PC+4, 1 = branch target
- ir_we  output  1  IR load enable
- reg_we  output  1  register file write enable
- reg2loc  output  1  1 = read Rt (STUR/CBZ), 0 = read Rm
- alu_src  output  1  0 = register B, 1 = sign-extended immediate
- alu_op  output  2  00 add, 01 pass-B (CBZ), 10 R-type decode
- mem_rd  output  1  memory read request
- mem_wr  output  1  memory write request
- mem_to_reg  output  1  1 = write-back data comes from memory
- illegal  output  1  one-cycle pulse on an undecodable opcode
- state  output  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_LD=7, BRANCH=8. Encodings 9-15 are unreachable and return to FETCH on the next clock.
- Reset: state <= FETCH. While reset=1, every output is 0 except state=0. Reset asserted in any state (including a memory wait) abandons the instruction; there is no write-back.
- FETCH: mem_rd=1.
  - mem_ready=0: hold in FETCH, pc_we=ir_we=0.
  - mem_ready=1: pc_we=1, ir_we=1, pc_src=0; next state DECODE.
- DECODE: reg2loc=1 for STUR and CBZ. Opcode decode:
  - 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR -> EXEC_R
  - 11111000010 LDUR, 11111000000 STUR -> ADDR
  - 10110100xxx CBZ (low 3 bits ignored) -> BRANCH
  - anything else: illegal=1 for this cycle only -> FETCH. The PC has already advanced, so the instruction is skipped.
- EXEC_R: alu_src=0, alu_op=10 -> WB_R.
- WB_R: reg_we=1, mem_to_reg=0, alu_op=10 -> FETCH.
- ADDR: alu_src=1, alu_op=00, reg2loc held per opcode. LDUR -> MEM_RD, STUR -> MEM_WR.
- MEM_RD: mem_rd=1, alu_src=1. Hold while mem_ready=0; on mem_ready=1 -> WB_LD.
- WB_LD: reg_we=1, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_wr=1, reg2loc=1, alu_src=1. Hold while mem_ready=0; on mem_ready=1 -> FETCH. mem_wr stays high for every wait cycle.
- BRANCH: reg2loc=1, alu_op=01, pc_src=1, pc_we=zero -> FETCH.
- mem_rd and mem_wr are never high in the same cycle. reg_we is high only in WB_R and WB_LD.
- Outputs not listed for a state are 0. Outputs are Moore except three Mealy terms: pc_we/ir_we in FETCH (gated by mem_ready) and pc_we in BRANCH (gated by zero).
- Minimum latency with mem_ready tied 1: R-type 4, LDUR 5, STUR 4, CBZ 3 cycles. Each memory wait cycle adds 1.

Optional Feature:
- Macro: MULTICYCLE_RETIRE_CNT_EN.
- Defined:
  - Adds output retired [CNT_W-1:0].
  - Reset value 0. Increments by 1 on the clock edge leaving WB_R, WB_LD, MEM_WR (with mem_ready=1) or BRANCH.
  - Illegal instructions are not counted.
  - Wraps from all-ones to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset 5 cycles, mem_ready=1 -> state=0, all outputs 0 during reset; first cycle after reset: mem_rd=1, pc_we=1, ir_we=1.
- ADD (10001011000), mem_ready=1 -> state sequence 0,1,2,6,0; reg_we=1 only in state 6 with alu_op=10.
- LDUR (11111000010), mem_ready low for 3 cycles in MEM_RD -> sequence 0,1,3,4,4,4,4,7,0; mem_rd held all 4 MEM_RD cycles; reg_we=1 and mem_to_reg=1 in 7.
- CBZ (10110100101), first with zero=1 then zero=0 -> pc_we=1 with pc_src=1 in BRANCH for zero=1; pc_we=0 for zero=0; both take 3 cycles.
- Opcode 00000000000 -> illegal pulses once in DECODE, next state FETCH, no reg_we or mem_wr.
- STUR with reset asserted during the MEM_WR wait -> next cycle state=0, mem_wr=0; with MULTICYCLE_RETIRE_CNT_EN, retired=0; without reset, 3 completed ADDs give retired=3.
